// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial LSB-first subtractor producing {borrow, a-b}.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   d,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   d_q, d_d;

  logic w_diff;
  logic w_br;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == LAST_BIT) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operands shift right so bit 0 is always the bit being resolved.
  assign w_diff = a_q[0] ^ b_q[0] ^ br_q;
  assign w_br   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    br_d  = br_q;
    cnt_d = cnt_q;
    d_d   = d_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          br_d  = 1'b0;
          cnt_d = '0;
        end
      end
      S_SHIFT: begin
        a_d              = a_q >> 1;
        b_d              = b_q >> 1;
        br_d             = w_br;
        cnt_d            = cnt_q + 1'b1;
        d_d[WIDTH-1:0]   = {w_diff, d_q[WIDTH-1:1]};
        if (cnt_q == LAST_BIT) begin
          d_d[WIDTH] = w_br;
        end
      end
      default: begin
      end
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    d         = d_q;
  end

endmodule
`default_nettype wire
